// File: rtl/receive_packet_pkg.sv
// Shared types and constants for the receive_packet block: FSM states,
// header word layout, TSE error width and the byte-length saturation helper.
package receive_packet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HUNT = 2'd1,
    DATA = 2'd2,
    HDR  = 2'd3
  } state_e;

  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_ERR_BIT   = 16;
  localparam int HDR_TRUNC_BIT = 17;
  localparam int TSE_ERR_W     = 6;

  function automatic logic [15:0] sat_len(input logic [31:0] bytes);
    return (bytes > 32'h0000_FFFF) ? 16'hFFFF : bytes[15:0];
  endfunction

endpackage

// File: rtl/receive_packet.sv
// Stores one TSE MAC RX frame into packet RAM: payload at base+1.., header at base.
// Optional frame/error counters are enabled by defining RECEIVE_PACKET_STATS_EN.
module receive_packet
  import receive_packet_pkg::*;
#(
  parameter int MAX_WORDS = 384,
  parameter int ADDR_W    = 25
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_W-1:0]    start_ram_addr,
  input  logic                 cmd_arm,
  output logic                 busy,
  output logic                 pkt_done,
  output logic [15:0]          pkt_len,
  output logic                 pkt_err,
  output logic                 pkt_trunc,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [1:0]           in_empty,
  input  logic [TSE_ERR_W-1:0] in_error,
  output logic [ADDR_W-1:0]    avm_address,
  output logic                 avm_write,
  output logic [31:0]          avm_writedata,
  input  logic                 avm_waitrequest
`ifdef RECEIVE_PACKET_STATS_EN
  ,
  output logic [31:0]          stat_frames,
  output logic [31:0]          stat_errors
`endif
);

  localparam int          CNT_W     = $clog2(MAX_WORDS + 1);
  localparam logic [31:0] MAX_BYTES = 32'(MAX_WORDS * 4);

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q, trunc_q, rehunt_q, hdr_issued_q;
  logic [15:0]         len_q;
  logic                busy_q, pkt_done_q, pkt_err_q, pkt_trunc_q;
  logic [15:0]         pkt_len_q;
  logic [ADDR_W-1:0]   avm_address_q;
  logic                avm_write_q;
  logic [31:0]         avm_writedata_q;

  logic                can_load, room, hdr_accept;
  logic [31:0]         cnt_inc;
  logic [15:0]         eop_len, cut_len, hunt_len;
  logic [ADDR_W-1:0]   wr_addr;
  logic [31:0]         hdr_word;

  // The single write register can take a new word when empty or being accepted now.
  assign can_load   = !avm_write_q || !avm_waitrequest;
  assign room       = 32'(cnt_q) < 32'(MAX_WORDS);
  assign cnt_inc    = 32'(cnt_q) + 32'(room);
  assign wr_addr    = base_q + ADDR_W'(1) + ADDR_W'(cnt_q);
  assign hdr_accept = (state_q == HDR) && hdr_issued_q && avm_write_q && !avm_waitrequest;

  always_comb begin
    eop_len  = room ? sat_len((cnt_inc << 2) - 32'(in_empty)) : sat_len(MAX_BYTES);
    cut_len  = trunc_q ? sat_len(MAX_BYTES) : sat_len(32'(cnt_q) << 2);
    hunt_len = sat_len(32'd4 - 32'(in_empty));
    hdr_word = '0;
    hdr_word[HDR_LEN_LSB +: 16] = len_q;
    hdr_word[HDR_ERR_BIT]       = err_q;
    hdr_word[HDR_TRUNC_BIT]     = trunc_q;
  end

  // A sop arriving mid-frame is held off until the current frame's header is out.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      HUNT:    in_ready = 1'b1;
      DATA:    in_ready = can_load && !(in_valid && in_sop);
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      cnt_q           <= '0;
      err_q           <= 1'b0;
      trunc_q         <= 1'b0;
      rehunt_q        <= 1'b0;
      hdr_issued_q    <= 1'b0;
      len_q           <= '0;
      busy_q          <= 1'b0;
      pkt_done_q      <= 1'b0;
      pkt_len_q       <= '0;
      pkt_err_q       <= 1'b0;
      pkt_trunc_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      if (avm_write_q && !avm_waitrequest) avm_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_arm) begin
            base_q      <= start_ram_addr;
            busy_q      <= 1'b1;
            pkt_len_q   <= '0;
            pkt_err_q   <= 1'b0;
            pkt_trunc_q <= 1'b0;
            rehunt_q    <= 1'b0;
            state_q     <= HUNT;
          end
        end
        HUNT: begin
          if (in_valid && in_sop) begin
            avm_write_q     <= 1'b1;
            avm_address_q   <= base_q + ADDR_W'(1);
            avm_writedata_q <= in_data;
            cnt_q           <= CNT_W'(1);
            err_q           <= |in_error;
            trunc_q         <= 1'b0;
            rehunt_q        <= 1'b0;
            hdr_issued_q    <= 1'b0;
            len_q           <= hunt_len;
            state_q         <= in_eop ? HDR : DATA;
          end
        end
        DATA: begin
          if (in_valid && in_sop) begin
            err_q        <= 1'b1;
            len_q        <= cut_len;
            rehunt_q     <= 1'b1;
            hdr_issued_q <= 1'b0;
            state_q      <= HDR;
          end else if (in_valid && can_load) begin
            err_q <= err_q | (|in_error);
            if (room) begin
              avm_write_q     <= 1'b1;
              avm_address_q   <= wr_addr;
              avm_writedata_q <= in_data;
              cnt_q           <= cnt_q + CNT_W'(1);
            end else begin
              trunc_q <= 1'b1;
            end
            if (in_eop) begin
              len_q        <= eop_len;
              hdr_issued_q <= 1'b0;
              state_q      <= HDR;
            end
          end
        end
        HDR: begin
          if (!hdr_issued_q) begin
            if (can_load) begin
              avm_write_q     <= 1'b1;
              avm_address_q   <= base_q;
              avm_writedata_q <= hdr_word;
              hdr_issued_q    <= 1'b1;
            end
          end else if (hdr_accept) begin
            pkt_done_q  <= 1'b1;
            busy_q      <= rehunt_q;
            pkt_len_q   <= len_q;
            pkt_err_q   <= err_q;
            pkt_trunc_q <= trunc_q;
            rehunt_q    <= 1'b0;
            state_q     <= rehunt_q ? HUNT : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign pkt_done      = pkt_done_q;
  assign pkt_len       = pkt_len_q;
  assign pkt_err       = pkt_err_q;
  assign pkt_trunc     = pkt_trunc_q;
  assign avm_address   = avm_address_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_writedata_q;

`ifdef RECEIVE_PACKET_STATS_EN
  logic [31:0] stat_frames_q, stat_errors_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_frames_q <= '0;
      stat_errors_q <= '0;
    end else if (hdr_accept) begin
      stat_frames_q <= stat_frames_q + 32'd1;
      if (err_q || trunc_q) stat_errors_q <= stat_errors_q + 32'd1;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_receive_packet.sv
// Scoreboard bench for receive_packet (MAX_WORDS=16 so the exact-fit and
// truncation boundaries are reachable with short frames).
module tb_receive_packet;

  localparam int MAXW = 16;
  localparam int AW   = 25;
  localparam int W    = 57;

  logic          clk, reset_n;
  logic [AW-1:0] start_ram_addr;
  logic          cmd_arm;
  logic          busy, pkt_done, pkt_err, pkt_trunc;
  logic [15:0]   pkt_len;
  logic [31:0]   in_data;
  logic          in_valid, in_ready, in_sop, in_eop;
  logic [1:0]    in_empty;
  logic [5:0]    in_error;
  logic [AW-1:0] avm_address;
  logic          avm_write;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest;
`ifdef RECEIVE_PACKET_STATS_EN
  logic [31:0]   stat_frames, stat_errors;
`endif

  receive_packet #(.MAX_WORDS(MAXW), .ADDR_W(AW)) u_dut (
    .clk(clk), .reset_n(reset_n), .start_ram_addr(start_ram_addr), .cmd_arm(cmd_arm),
    .busy(busy), .pkt_done(pkt_done), .pkt_len(pkt_len), .pkt_err(pkt_err), .pkt_trunc(pkt_trunc),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_error(in_error), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest)
`ifdef RECEIVE_PACKET_STATS_EN
    , .stat_frames(stat_frames), .stat_errors(stat_errors)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];
  logic [18:0]  done_q[$];
  logic [W-1:0] mon_e;
  logic [18:0]  mon_d;

  logic [AW-1:0] m_base;
  int            m_cnt, m_frames, m_errs;
  bit            m_open, m_err, m_trunc, m_busy;
  logic [31:0]   fdata[64];

  bit            stall_en;
  int            stall_left, wr_cnt;
  int            last_stalled = -1;
  bit            prev_stall, prev_done;
  logic [AW-1:0] prev_addr;
  logic [31:0]   prev_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: write master, completion reporting and stall behaviour.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_addr", avm_address, prev_addr);
          chk("hold_data", avm_writedata, prev_data);
          chk("hold_write", avm_write, 1'b1);
        end
        if (avm_write && avm_waitrequest) chk("ready_in_stall", in_ready, 1'b0);
        if (avm_write && !avm_waitrequest) begin
          wr_cnt++;
          if (exp_q.size() == 0) chk("write_expected", avm_write, 1'b0);
          else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", avm_address, mon_e[56:32]);
            chk("wr_data", avm_writedata, mon_e[31:0]);
          end
        end
        if (prev_done) chk("done_pulse", pkt_done, 1'b0);
        else if (pkt_done) begin
          if (done_q.size() == 0) chk("done_expected", pkt_done, 1'b0);
          else begin
            mon_d = done_q.pop_front();
            chk("pkt_len", pkt_len, mon_d[15:0]);
            chk("pkt_err", pkt_err, mon_d[16]);
            chk("pkt_trunc", pkt_trunc, mon_d[17]);
            chk("busy_after_done", busy, mon_d[18]);
          end
        end
        prev_stall = avm_write && avm_waitrequest;
        prev_addr  = avm_address;
        prev_data  = avm_writedata;
        prev_done  = pkt_done;
      end
    end
  end

  // Slave stall pattern: every 4th write is held off for 3 cycles.
  initial begin
    avm_waitrequest = 1'b0;
    stall_left = 0;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) stall_left--;
      if (stall_left == 0 && stall_en && reset_n && avm_write &&
          (wr_cnt % 4 == 3) && last_stalled != wr_cnt) begin
        stall_left   = 3;
        last_stalled = wr_cnt;
      end
      avm_waitrequest = (stall_left > 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic model_close(input bit is_eop, input int emp);
    int          len;
    logic [15:0] l16;
    if (!is_eop) m_err = 1'b1;
    len = m_trunc ? MAXW * 4 : m_cnt * 4 - (is_eop ? emp : 0);
    l16 = 16'(len);
    exp_q.push_back({m_base, 14'd0, m_trunc, m_err, l16});
    done_q.push_back({!is_eop, m_trunc, m_err, l16});
    m_busy = !is_eop;
    m_frames++;
    if (m_err || m_trunc) m_errs++;
    m_open = 1'b0;
  endtask

  task automatic arm(input logic [AW-1:0] a);
    if (!m_busy) begin
      m_base = a;
      m_busy = 1'b1;
    end
    start_ram_addr = a;
    cmd_arm = 1'b1;
    @(posedge clk); #1;
    cmd_arm = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input bit sop, input bit eop,
                           input logic [1:0] emp, input logic [5:0] er);
    int t;
    if (sop && m_open) model_close(1'b0, 0);
    if (sop) begin
      m_open = 1'b1; m_cnt = 0; m_err = 1'b0; m_trunc = 1'b0;
    end
    if (m_open) begin
      if (er != 0) m_err = 1'b1;
      if (m_cnt < MAXW) begin
        exp_q.push_back({m_base + AW'(1 + m_cnt), d});
        m_cnt++;
      end else m_trunc = 1'b1;
      if (eop) model_close(1'b1, int'(emp));
    end
    in_data = d; in_sop = sop; in_eop = eop; in_empty = emp; in_error = er;
    in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        chk("beat_accept", in_ready, 1'b1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_error = '0; in_empty = '0;
  endtask

  task automatic send_frame(input int n, input logic [1:0] emp, input logic [5:0] err_last,
                            input bit with_eop);
    for (int i = 0; i < n; i++)
      send_beat(fdata[i], i == 0, with_eop && (i == n - 1),
                (i == n - 1) ? emp : 2'd0, (i == n - 1) ? err_last : 6'd0);
  endtask

  task automatic fill_data();
    for (int i = 0; i < 64; i++) fdata[i] = $urandom;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", exp_q.size() + done_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("busy_idle", busy, m_busy);
  endtask

  task automatic check_stats();
`ifdef RECEIVE_PACKET_STATS_EN
    chk("stat_frames", stat_frames, m_frames);
    chk("stat_errors", stat_errors, m_errs);
`endif
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", pkt_done, 1'b0);
    chk("rst_len", pkt_len, 16'd0);
    chk("rst_err", pkt_err, 1'b0);
    chk("rst_trunc", pkt_trunc, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_write", avm_write, 1'b0);
    chk("rst_addr", avm_address, 25'd0);
    chk("rst_wdata", avm_writedata, 32'd0);
    check_stats();
  endtask

  initial begin
    reset_n = 1'b0; cmd_arm = 1'b0; start_ram_addr = '0; stall_en = 1'b0;
    in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = '0; in_error = '0;
    m_busy = 1'b0; m_open = 1'b0; m_frames = 0; m_errs = 0; wr_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // 16 beats exactly fills MAX_WORDS without truncating; header 0x3E
    fill_data();
    arm(25'h000100);
    send_frame(16, 2'd2, 6'd0, 1'b1);
    wait_drain();

    // same frame under slave stalls
    stall_en = 1'b1;
    arm(25'h000100);
    send_frame(16, 2'd2, 6'd0, 1'b1);
    wait_drain();
    stall_en = 1'b0;

    // junk beats in HUNT are discarded, then a 2-beat frame
    fill_data();
    arm(25'h000300);
    send_beat($urandom, 1'b0, 1'b0, 2'd0, 6'd0);
    send_beat($urandom, 1'b0, 1'b1, 2'd1, 6'd0);
    send_beat($urandom, 1'b0, 1'b0, 2'd0, 6'd0);
    send_frame(2, 2'd1, 6'd0, 1'b1);
    wait_drain();

    // oversize frame truncates at MAX_WORDS
    fill_data();
    arm(25'h000400);
    send_frame(18, 2'd3, 6'd0, 1'b1);
    wait_drain();

    // MAC error on the eop beat; an arm while busy is ignored
    fill_data();
    arm(25'h000500);
    send_beat(fdata[0], 1'b1, 1'b0, 2'd0, 6'd0);
    arm(25'h000777);
    send_beat(fdata[1], 1'b0, 1'b0, 2'd0, 6'd0);
    send_beat(fdata[2], 1'b0, 1'b1, 2'd0, 6'h02);
    wait_drain();
    check_stats();

    // sop mid-frame closes the open frame with err and re-hunts without re-arm
    fill_data();
    arm(25'h000600);
    send_frame(3, 2'd0, 6'd0, 1'b0);
    send_frame(2, 2'd0, 6'd0, 1'b1);
    wait_drain();

    // reset in the middle of DATA aborts the frame
    fill_data();
    arm(25'h000700);
    send_frame(5, 2'd0, 6'd0, 1'b0);
    reset_n = 1'b0;
    #2;
    check_reset_outputs();
    exp_q.delete(); done_q.delete();
    m_open = 1'b0; m_busy = 1'b0; m_frames = 0; m_errs = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    arm(25'h000800);
    send_frame(4, 2'd0, 6'd0, 1'b1);
    wait_drain();

    // single-beat frame under stalls, then an address-wrapping frame
    stall_en = 1'b1;
    fill_data();
    arm(25'h000900);
    send_frame(1, 2'd3, 6'd0, 1'b1);
    wait_drain();
    fill_data();
    arm(25'h1FFFFFE);
    send_frame(4, 2'd0, 6'd0, 1'b1);
    wait_drain();
    stall_en = 1'b0;

    check_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/receive_packet.md
Name: receive_packet

Overview:
- Receive-side counterpart of the send_packet block: takes one Ethernet frame from the TSE MAC RX Avalon-ST source and stores it in packet RAM at a host-given word address.
- Once armed, writes the payload words from start_ram_addr+1 through an Avalon-MM write master, then writes a header word at start_ram_addr.
- Reports completion, byte length and status.
- One instance per MAC port, in the MAC clock domain.

Parameters:
- MAX_WORDS, 384, maximum payload words stored per frame (1536 bytes); beats beyond this are dropped.
- ADDR_W, 25, RAM word-address width.

Ports:
- clk  in  1  MAC/system clock
- reset_n  in  1  asynchronous active-low reset
- start_ram_addr  in  25  header word address, sampled on cmd_arm
- cmd_arm  in  1  single-cycle pulse that arms reception of one frame
- busy  out  1  high from arm until pkt_done
- pkt_done  out  1  one-cycle pulse after the header write is accepted
- pkt_len  out  16  stored byte length, valid from pkt_done until the next arm
- pkt_err  out  1  MAC error seen on the frame
- pkt_trunc  out  1  frame exceeded MAX_WORDS
- in_data  in  32  Avalon-ST data, first byte in [31:24]
- in_valid  in  1  Avalon-ST valid
- in_ready  out  1  Avalon-ST ready, readyLatency 0
- in_sop  in  1  start of packet
- in_eop  in  1  end of packet
- in_empty  in  2  empty bytes on the eop beat
- in_error  in  6  TSE rx error vector
- avm_address  out  25  RAM word address
- avm_write  out  1  write request
- avm_writedata  out  32  write data
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal counters 0.
- IDLE:
  - in_ready=0.
  - cmd_arm captures start_ram_addr into base, sets busy=1, clears pkt_len/pkt_err/pkt_trunc, and moves to HUNT.
- HUNT:
  - in_ready=1; beats without in_sop are consumed and discarded.
  - A valid sop beat is written to base+1, word count becomes 1, FSM moves to DATA.
  - A single-beat frame (sop and eop together) goes straight to HDR once its write is accepted.
- DATA:
  - in_ready = !avm_write || !avm_waitrequest (a single write register, back-to-back throughput of one word per clock).
  - Each accepted beat with word count < MAX_WORDS issues a write to base+1+count (modulo 2^25) and increments count.
  - Beats at count == MAX_WORDS are consumed without a write and set the trunc flag.
  - The eop beat moves the FSM to HDR after its write (if any) is accepted.
- Write master:
  - avm_address, avm_write and avm_writedata are registered and held stable while avm_waitrequest=1.
  - avm_write is deasserted in the cycle after acceptance unless a new beat is loaded.
- Byte length:
  - Computed as count*4 - in_empty of the eop beat when not truncated, else MAX_WORDS*4.
  - Saturates at 16'hFFFF.
- Error flag: set if in_error != 0 on any accepted beat of the frame.
- HDR:
  - in_ready=0.
  - Writes to base: [15:0]=len, [16]=err, [17]=trunc, [31:18]=0.
  - On acceptance, pkt_done pulses for one clock, busy drops, pkt_len/pkt_err/pkt_trunc are updated, FSM returns to IDLE.
- cmd_arm while busy=1 is ignored.
- A sop seen in DATA before eop is treated as a new frame:
  - the current frame closes with err=1;
  - the sop beat is not consumed (in_ready=0 that cycle) until HDR is done;
  - the block then re-enters HUNT for the new frame, with no re-arm needed.
- Reset assertion mid-frame aborts immediately: no header write, no pkt_done.

Optional Feature:
- Macro RECEIVE_PACKET_STATS_EN.
- Defined:
  - adds outputs stat_frames[31:0] and stat_errors[31:0];
  - stat_frames increments on every pkt_done;
  - stat_errors increments on pkt_done when err or trunc is set;
  - both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent, with no other change.

Decomposition:
- Package receive_packet_pkg holds:
  - the state enum (IDLE, HUNT, DATA, HDR);
  - header bit positions (HDR_LEN_LSB=0, HDR_ERR_BIT=16, HDR_TRUNC_BIT=17);
  - the TSE error width constant (6).
- No sub-module; the stats counters stay inline under the macro.

Test Plan:
- Arm at 25'h000100, send a 16-beat frame with empty=2 and no stalls -> words written at 0x101..0x110, header at 0x100 = 32'h0000_003E, pkt_done one pulse, pkt_len=62.
- Same frame with avm_waitrequest high for 3 cycles on every 4th write -> same RAM contents, no beat lost or duplicated, in_ready low during stalls.
- 3 beats without sop in HUNT, then a 2-beat frame -> only the 2 frame words written, pkt_len=8-empty.
- MAX_WORDS=4, 6-beat frame -> 4 data writes, header bit17=1, pkt_len=16, pkt_trunc=1.
- in_error=6'h02 on the eop beat -> header bit16=1, pkt_err=1; with RECEIVE_PACKET_STATS_EN, stat_errors=1 and stat_frames=1.
- reset_n low in the middle of DATA -> all outputs 0, no header write; after re-arm, the next frame is stored correctly.
